arbitro_rr: RTL and testbench

- Round-robin arbiter that shares the 4:1 datapath mux between four input FIFOs and one downstream FIFO.
- Each cycle it picks at most one non-empty input FIFO and pops it.
- One cycle later it drives the mux selector and the downstream push, aligned with the FIFO's registered read data.
- Sits between the input FIFO bank and the mux/output FIFO in the transaction path.

---
 rtl/arbitro_rr_if.sv | 31 +++
 rtl/arbitro_rr.sv | 128 ++++++++++++
 tb/tb_arbitro_rr.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/arbitro_rr_if.sv
// ---------------------------------------------------------------------------
// arbitro_rr_if
// Groups the arbiter's FIFO-side handshake signals into one bundle.
//   enb          arbiter enable (1 = grants allowed)
//   empty[3:0]   empty flags of input FIFOs 0..3
//   almost_full  downstream FIFO almost-full (1 = grants blocked)
//   pop[3:0]     one-hot read strobe to the input FIFOs
//   selector[1:0] registered mux selector
//   push         registered downstream write strobe
//   idle         registered: previous cycle issued no grant
// Modports: master = environment side (FIFO bank / mux), slave = arbiter.
// ---------------------------------------------------------------------------
interface arbitro_rr_if;
    logic       enb;
    logic [3:0] empty;
    logic       almost_full;
    logic [3:0] pop;
    logic [1:0] selector;
    logic       push;
    logic       idle;

    modport master (
        output enb, empty, almost_full,
        input  pop, selector, push, idle
    );

    modport slave (
        input  enb, empty, almost_full,
        output pop, selector, push, idle
    );
endinterface

// File: rtl/arbitro_rr.sv
// ---------------------------------------------------------------------------
// arbitro_rr
// Round-robin arbiter sharing the 4:1 datapath mux between four input FIFOs
// and one downstream FIFO. Each cycle it pops at most one non-empty input
// FIFO; one cycle later it drives selector/push, aligned with the FIFO's
// registered read data.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    arbitro_rr_if.slave (enb, empty, almost_full -> pop, selector,
//          push, idle)
// Parameters:
//   NUM_REQ    number of requesters, must be 4 (2-bit selector)
//   MAX_BURST  max consecutive grants to one owner (1..15), ARB_BURST_EN only
// Configuration macro:
//   ARB_BURST_EN  when defined, the current owner may keep the grant for up
//                 to MAX_BURST consecutive cycles before rotation.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | previous cycle issued no grant (idle=1)
// ST_ACTIVE | previous cycle issued a grant (push pending now)
// ---------------------------------------------------------------------------
module arbitro_rr #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           reset,
    arbitro_rr_if.slave    bus
);

    if (NUM_REQ != 4) begin : g_bad_num_req
        $error("arbitro_rr: NUM_REQ must be 4");
    end
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
        $error("arbitro_rr: MAX_BURST must be within 1..15");
    end

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [1:0] selector_q, selector_d;
    logic       push_q, push_d;

    logic [3:0] req;
    logic       grant_ok;
    logic       found;
    logic [1:0] cand;
    logic [1:0] gnt_idx;
    logic [3:0] pop_c;

`ifdef ARB_BURST_EN
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);
    logic [3:0] burst_q, burst_d;
    logic       keep;
`endif

    always_comb begin
        req      = ~bus.empty;
        grant_ok = bus.enb & ~bus.almost_full & ~reset & (|req);

        // Search (last+1), (last+2), ... wrapping; k=NUM_REQ lands on last itself.
        found   = 1'b0;
        cand    = 2'd0;
        gnt_idx = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last_q + 2'(k);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end

`ifdef ARB_BURST_EN
        // Owner keeps the grant only inside an unbroken run of grants; the
        // counter already includes the owner's first grant of the run.
        keep = (state_q == ST_ACTIVE) && (burst_q != 4'd0) &&
               (burst_q < BURST_LIM) && req[last_q];
        if (keep) begin
            gnt_idx = last_q;
        end
        burst_d = 4'd0;
        if (grant_ok) begin
            burst_d = keep ? burst_q + 4'd1 : 4'd1;
        end
`endif

        pop_c      = grant_ok ? (4'b0001 << gnt_idx) : 4'b0000;
        state_d    = grant_ok ? ST_ACTIVE : ST_IDLE;
        last_d     = grant_ok ? gnt_idx : last_q;
        selector_d = grant_ok ? gnt_idx : selector_q;
        push_d     = grant_ok;
    end

    // A push registered before reset is still presented in the reset cycle;
    // reset only clears what follows, and pop is blocked during reset so no
    // new push is ever scheduled from a reset cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_q     <= 2'd3;
            selector_q <= 2'd0;
            push_q     <= 1'b0;
`ifdef ARB_BURST_EN
            burst_q    <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            selector_q <= selector_d;
            push_q     <= push_d;
`ifdef ARB_BURST_EN
            burst_q    <= burst_d;
`endif
        end
    end

    assign bus.pop      = pop_c;
    assign bus.selector = selector_q;
    assign bus.push     = push_q;
    assign bus.idle     = (state_q == ST_IDLE);

endmodule

// File: tb/tb_arbitro_rr.sv
// ---------------------------------------------------------------------------
// tb_arbitro_rr
// Scoreboard bench for arbitro_rr. The driver applies inputs on the falling
// edge, evaluates a reference model of the arbitration rules and queues the
// expected per-cycle outputs plus the expected pushes; a separate monitor
// samples the DUT shortly after the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_arbitro_rr;

    localparam int MAXB = 2;

    logic clk;
    logic reset;

    arbitro_rr_if bus ();

    arbitro_rr #(.NUM_REQ(4), .MAX_BURST(MAXB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] pop;
        logic [3:0] empty;
        logic [1:0] sel;
        logic       idle;
    } cyc_item_t;

    typedef struct {
        int         cyc;
        logic [1:0] idx;
    } push_item_t;

    cyc_item_t  cyc_q[$];
    push_item_t push_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // reference model state
    int m_last  = 3;
    int m_sel   = 0;
    bit m_idle  = 1'b1;
    int m_burst = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs and record what the DUT must show.
    task automatic drive(input bit rst, input bit en, input logic [3:0] emp, input bit af);
        cyc_item_t  it;
        push_item_t pi;
        int         g;
        bit         keep;
        @(negedge clk);
        cyc++;
        reset           = rst;
        bus.enb         = en;
        bus.empty       = emp;
        bus.almost_full = af;

        it.cyc   = cyc;
        it.empty = emp;
        it.sel   = 2'(m_sel);
        it.idle  = m_idle;
        it.pop   = 4'b0000;
        g = -1;
        if (!rst && en && !af && emp != 4'b1111) begin
            keep = 1'b0;
`ifdef ARB_BURST_EN
            keep = (m_burst > 0) && (m_burst < MAXB) && !emp[m_last];
`endif
            if (keep) begin
                g = m_last;
                m_burst++;
            end else begin
                for (int k = 1; k <= 4 && g < 0; k++)
                    if (!emp[(m_last + k) % 4]) g = (m_last + k) % 4;
                m_burst = 1;
            end
        end
        if (rst) begin
            m_last = 3; m_sel = 0; m_idle = 1'b1; m_burst = 0;
        end else if (g >= 0) begin
            it.pop = 4'(1 << g);
            m_last = g; m_sel = g; m_idle = 1'b0;
            pi.cyc = cyc;
            pi.idx = 2'(g);
            push_q.push_back(pi);
        end else begin
            m_idle = 1'b1; m_burst = 0;
        end
        cyc_q.push_back(it);
    endtask

    // Monitor
    initial begin
        cyc_item_t  it;
        push_item_t pi;
        forever begin
            @(negedge clk);
            #2;
            if (cyc_q.size() != 0) begin
                it = cyc_q.pop_front();
                check("pop", int'(bus.pop), int'(it.pop));
                check("pop_onehot", int'($countones(bus.pop) <= 1), 1);
                check("pop_while_empty", int'(bus.pop & it.empty), 0);
                check("selector", int'(bus.selector), int'(it.sel));
                check("idle", int'(bus.idle), int'(it.idle));
                if (bus.push === 1'b1) begin
                    if (push_q.size() == 0 || push_q[0].cyc >= it.cyc) begin
                        check("push_unexpected", 1, 0);
                    end else begin
                        pi = push_q.pop_front();
                        check("push_latency", it.cyc - pi.cyc, 1);
                        check("push_sel", int'(bus.selector), int'(pi.idx));
                    end
                end else begin
                    check("push_x", int'(bus.push === 1'b0), 1);
                    if (push_q.size() != 0 && push_q[0].cyc < it.cyc) begin
                        pi = push_q.pop_front();
                        check("push_dropped", 0, 1);
                    end
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        bus.enb         = 1'b0;
        bus.empty       = 4'b1111;
        bus.almost_full = 1'b0;

        // all FIFOs empty: nothing happens
        drive(1, 1, 4'b1111, 0);
        repeat (5) drive(0, 1, 4'b1111, 0);
        // all requesting: full rotation
        drive(1, 1, 4'b0000, 0);
        repeat (8) drive(0, 1, 4'b0000, 0);
        // only 0 and 2
        repeat (6) drive(0, 1, 4'b1010, 0);
        // single requester
        repeat (4) drive(0, 1, 4'b1011, 0);
        // almost_full for 3 cycles mid-stream, then resume
        repeat (3) drive(0, 1, 4'b0000, 0);
        repeat (3) drive(0, 1, 4'b0000, 1);
        repeat (4) drive(0, 1, 4'b0000, 0);
        // reset mid-stream
        drive(1, 1, 4'b0000, 0);
        repeat (4) drive(0, 1, 4'b0000, 0);
        // enb low
        repeat (2) drive(0, 0, 4'b0000, 0);
        repeat (3) drive(0, 1, 4'b0110, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 90),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 99) < 20));
        end

        // drain
        repeat (3) drive(0, 1, 4'b1111, 0);
        @(negedge clk);
        #4;
        check("cycle_queue_drained", cyc_q.size(), 0);
        check("push_queue_drained", push_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
